// File: rtl/perf_counter_unit_if.sv
// Snapshot handshake between the performance counter bank and a debug reader.
// The reader (master) requests, selects and acknowledges. The counter unit (slave) presents the copy.
interface perf_counter_unit_if #(
  parameter int CNT_W = 32
);
  logic             snap_req;
  logic             snap_ack;
  logic [2:0]       snap_sel;
  logic             snap_valid;
  logic [CNT_W-1:0] snap_data;

  modport master (
    output snap_req, snap_ack, snap_sel,
    input  snap_valid, snap_data
  );

  modport slave (
    input  snap_req, snap_ack, snap_sel,
    output snap_valid, snap_data
  );
endinterface

// File: rtl/perf_counter_unit.sv
// Five-entry pipeline event counter bank.
// It also keeps a single-cycle-coherent snapshot copy behind a req/ack handshake.
module perf_counter_unit #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count_en,
  input  logic             clear,
  input  logic             retire_valid,
  input  logic             pipe_stall,
  input  logic             icache_stall,
  input  logic             branch_resolved,
  input  logic             branch_mispredict,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instruction_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] branch_mispredicts,
  perf_counter_unit_if.slave snap
);

  localparam int N_CNT = 5;
  localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } snap_state_t;

  snap_state_t      state_r;
  snap_state_t      state_nxt_s;
  logic             load_s;
  logic [N_CNT-1:0] inc_s;
  logic [CNT_W-1:0] cnt_r     [N_CNT];
  logic [CNT_W-1:0] cnt_nxt_s [N_CNT];
  logic [CNT_W-1:0] snap_r    [N_CNT];
  logic [CNT_W-1:0] snap_mux_s;

  // One-step increment that either wraps or sticks at all-ones.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic inc);
    if (!inc) begin
      return v;
    end else if (SATURATE && (v == ALL_ONES)) begin
      return v;
    end else begin
      return v + ONE;
    end
  endfunction

  // Event decode and next value of every live counter; clear beats any event.
  always_comb begin
    inc_s = {branch_resolved & branch_mispredict,
             branch_resolved,
             pipe_stall | icache_stall,
             retire_valid,
             1'b1};
    for (int i = 0; i < N_CNT; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (clear) begin
        cnt_nxt_s[i] = '0;
      end else if (count_en) begin
        cnt_nxt_s[i] = bump(cnt_r[i], inc_s[i]);
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // Live counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_CNT; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CNT; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // Snapshot handshake next state; a capture takes the counters' next values.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (snap.snap_req) begin
          state_nxt_s = ST_HELD;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (snap.snap_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HELD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Snapshot state and copy registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      for (int i = 0; i < N_CNT; i++) begin
        snap_r[i] <= '0;
      end
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        for (int i = 0; i < N_CNT; i++) begin
          snap_r[i] <= cnt_nxt_s[i];
        end
      end
    end
  end

  // Read-side selection of the held copy; unused selects read as zero.
  always_comb begin
    snap_mux_s = '0;
    case (snap.snap_sel)
      3'd0:    snap_mux_s = snap_r[0];
      3'd1:    snap_mux_s = snap_r[1];
      3'd2:    snap_mux_s = snap_r[2];
      3'd3:    snap_mux_s = snap_r[3];
      3'd4:    snap_mux_s = snap_r[4];
      default: snap_mux_s = '0;
    endcase
  end

  assign cycle_count        = cnt_r[0];
  assign instruction_count  = cnt_r[1];
  assign stall_count        = cnt_r[2];
  assign branch_count       = cnt_r[3];
  assign branch_mispredicts = cnt_r[4];
  assign snap.snap_valid    = (state_r == ST_HELD);
  assign snap.snap_data     = snap_mux_s;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Bench for perf_counter_unit: three instances (32-bit wrap, 4-bit wrap, 4-bit saturate).
// The instances share stimulus and are compared each cycle against an arithmetic reference model.
module tb_perf_counter_unit;

  logic       clk;
  logic       reset;
  logic       count_en;
  logic       clear;
  logic       retire_valid;
  logic       pipe_stall;
  logic       icache_stall;
  logic       branch_resolved;
  logic       branch_mispredict;
  logic       snap_req;
  logic       snap_ack;
  logic [2:0] snap_sel;

  logic [31:0] c0 [5];
  logic [3:0]  c1 [5];
  logic [3:0]  c2 [5];

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: unbounded-integer counts folded to each width, plus snapshot copy.
  longint unsigned m_cnt  [3][5];
  longint unsigned m_snap [3][5];
  bit              m_held [3];

  perf_counter_unit_if #(.CNT_W(32)) if0 ();
  perf_counter_unit_if #(.CNT_W(4))  if1 ();
  perf_counter_unit_if #(.CNT_W(4))  if2 ();

  assign if0.snap_req = snap_req;
  assign if0.snap_ack = snap_ack;
  assign if0.snap_sel = snap_sel;
  assign if1.snap_req = snap_req;
  assign if1.snap_ack = snap_ack;
  assign if1.snap_sel = snap_sel;
  assign if2.snap_req = snap_req;
  assign if2.snap_ack = snap_ack;
  assign if2.snap_sel = snap_sel;

  perf_counter_unit #(.CNT_W(32), .SATURATE(1'b0)) u_w32 (
    .clk(clk), .reset(reset), .count_en(count_en), .clear(clear),
    .retire_valid(retire_valid), .pipe_stall(pipe_stall), .icache_stall(icache_stall),
    .branch_resolved(branch_resolved), .branch_mispredict(branch_mispredict),
    .cycle_count(c0[0]), .instruction_count(c0[1]), .stall_count(c0[2]),
    .branch_count(c0[3]), .branch_mispredicts(c0[4]), .snap(if0.slave));

  perf_counter_unit #(.CNT_W(4), .SATURATE(1'b0)) u_w4_wrap (
    .clk(clk), .reset(reset), .count_en(count_en), .clear(clear),
    .retire_valid(retire_valid), .pipe_stall(pipe_stall), .icache_stall(icache_stall),
    .branch_resolved(branch_resolved), .branch_mispredict(branch_mispredict),
    .cycle_count(c1[0]), .instruction_count(c1[1]), .stall_count(c1[2]),
    .branch_count(c1[3]), .branch_mispredicts(c1[4]), .snap(if1.slave));

  perf_counter_unit #(.CNT_W(4), .SATURATE(1'b1)) u_w4_sat (
    .clk(clk), .reset(reset), .count_en(count_en), .clear(clear),
    .retire_valid(retire_valid), .pipe_stall(pipe_stall), .icache_stall(icache_stall),
    .branch_resolved(branch_resolved), .branch_mispredict(branch_mispredict),
    .cycle_count(c2[0]), .instruction_count(c2[1]), .stall_count(c2[2]),
    .branch_count(c2[3]), .branch_mispredicts(c2[4]), .snap(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_cnt(input int d, input int k);
    case (d)
      0:       return {32'd0, c0[k]};
      1:       return {60'd0, c1[k]};
      default: return {60'd0, c2[k]};
    endcase
  endfunction

  function automatic logic [63:0] dut_snap(input int d);
    case (d)
      0:       return {32'd0, if0.snap_data};
      1:       return {60'd0, if1.snap_data};
      default: return {60'd0, if2.snap_data};
    endcase
  endfunction

  function automatic logic dut_valid(input int d);
    case (d)
      0:       return if0.snap_valid;
      1:       return if1.snap_valid;
      default: return if2.snap_valid;
    endcase
  endfunction

  // Advance the reference by one clock edge using the inputs that were applied to it.
  task automatic model_step();
    bit              ev [5];
    longint unsigned nxt [5];
    longint unsigned top;
    ev[0] = 1'b1;
    ev[1] = retire_valid;
    ev[2] = pipe_stall || icache_stall;
    ev[3] = branch_resolved;
    ev[4] = branch_resolved && branch_mispredict;
    for (int d = 0; d < 3; d++) begin
      top = (d == 0) ? 64'hFFFF_FFFF : 64'hF;
      if (!reset) begin
        for (int k = 0; k < 5; k++) begin
          m_cnt[d][k]  = 0;
          m_snap[d][k] = 0;
        end
        m_held[d] = 1'b0;
      end else begin
        for (int k = 0; k < 5; k++) begin
          if (clear)                         nxt[k] = 0;
          else if (!count_en || !ev[k])      nxt[k] = m_cnt[d][k];
          else if (d == 2 && m_cnt[d][k] == top) nxt[k] = top;
          else                               nxt[k] = (m_cnt[d][k] + 1) % (top + 1);
        end
        if (!m_held[d] && snap_req) begin
          for (int k = 0; k < 5; k++) m_snap[d][k] = nxt[k];
          m_held[d] = 1'b1;
        end else if (m_held[d] && snap_ack) begin
          m_held[d] = 1'b0;
        end
        for (int k = 0; k < 5; k++) m_cnt[d][k] = nxt[k];
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] exp_snap;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 5; k++) begin
        check($sformatf("d%0d_cnt%0d", d, k), dut_cnt(d, k), m_cnt[d][k]);
      end
      check($sformatf("d%0d_snap_valid", d), {63'd0, dut_valid(d)}, {63'd0, m_held[d]});
      exp_snap = (snap_sel < 3'd5) ? m_snap[d][snap_sel] : 64'd0;
      check($sformatf("d%0d_snap_data_sel%0d", d, snap_sel), dut_snap(d), exp_snap);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_held[d] = 1'b0;
      for (int k = 0; k < 5; k++) begin
        m_cnt[d][k]  = 0;
        m_snap[d][k] = 0;
      end
    end
    // Reset held with every event and a snapshot request active.
    reset = 1'b0; count_en = 1'b1; clear = 1'b0;
    retire_valid = 1'b1; pipe_stall = 1'b1; icache_stall = 1'b1;
    branch_resolved = 1'b1; branch_mispredict = 1'b1;
    snap_req = 1'b1; snap_ack = 1'b0; snap_sel = 3'd0;
    repeat (3) tick();
    check("rst_cycle", {32'd0, c0[0]}, 64'd0);
    check("rst_valid", {63'd0, if0.snap_valid}, 64'd0);

    reset = 1'b1; snap_req = 1'b0;
    pipe_stall = 1'b0; icache_stall = 1'b0; branch_resolved = 1'b0; branch_mispredict = 1'b0;
    repeat (10) tick();
    check("t1_cycle", {32'd0, c0[0]}, 64'd10);
    check("t1_instr", {32'd0, c0[1]}, 64'd10);

    retire_valid = 1'b0; pipe_stall = 1'b1; icache_stall = 1'b1;
    repeat (4) tick();
    check("t2_stall", {32'd0, c0[2]}, 64'd4);
    pipe_stall = 1'b0; icache_stall = 1'b0;

    for (int i = 0; i < 5; i++) begin
      branch_resolved = 1'b1; branch_mispredict = (i < 2);
      tick();
    end
    branch_resolved = 1'b0; branch_mispredict = 1'b1;
    tick();
    branch_mispredict = 1'b0;
    check("t3_branch", {32'd0, c0[3]}, 64'd5);
    check("t3_mispred", {32'd0, c0[4]}, 64'd2);

    clear = 1'b1; retire_valid = 1'b1;
    tick();
    clear = 1'b0; retire_valid = 1'b0;
    check("t4_clr_instr", {32'd0, c0[1]}, 64'd0);
    repeat (3) tick();
    count_en = 1'b0;
    repeat (6) tick();
    check("t4_frozen_cycle", {32'd0, c0[0]}, 64'd3);
    count_en = 1'b1;

    repeat (17) tick();
    check("t5_pre_cycle", {32'd0, c0[0]}, 64'd20);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    check("t5_valid", {63'd0, if0.snap_valid}, 64'd1);
    check("t5_snap", {32'd0, if0.snap_data}, 64'd21);
    for (int i = 0; i < 5; i++) begin
      snap_req = (i == 2);
      tick();
      check("t5_snap_hold", {32'd0, if0.snap_data}, 64'd21);
    end
    for (int s = 0; s < 8; s++) begin
      snap_sel = s[2:0];
      #1;
      check_all();
    end
    snap_sel = 3'd0; snap_req = 1'b1; snap_ack = 1'b1;
    tick();
    snap_req = 1'b0; snap_ack = 1'b0;
    check("t5_ack_valid", {63'd0, if0.snap_valid}, 64'd0);
    tick();

    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (16) tick();
    check("t6_wrap", {60'd0, c1[0]}, 64'd0);
    check("t6_sat", {60'd0, c2[0]}, 64'd15);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    reset = 1'b0;
    tick();
    check("t6_rst_valid", {63'd0, if1.snap_valid}, 64'd0);
    reset = 1'b1;
    tick();

    // Randomized traffic across all controls.
    for (int i = 0; i < 3000; i++) begin
      reset             = ($urandom_range(63) != 0);
      clear             = ($urandom_range(15) == 0);
      count_en          = ($urandom_range(7) != 0);
      retire_valid      = $urandom_range(1);
      pipe_stall        = $urandom_range(1);
      icache_stall      = $urandom_range(1);
      branch_resolved   = $urandom_range(1);
      branch_mispredict = $urandom_range(1);
      snap_req          = ($urandom_range(3) == 0);
      snap_ack          = ($urandom_range(2) == 0);
      snap_sel          = 3'($urandom_range(7));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
